countdown_timer_4bit: RTL and testbench
=======================================

# countdown_timer_4bit

Loadable 4-bit down-counting timer: software or a sequencer loads a start value, issues `start`, and the block decrements once per clock until it reaches zero, then emits a one-cycle `done` pulse. It is the downward counterpart of the team's loadable 4-bit up counter. It sits beside that counter in the timing and sequencing logic and provides delays and periodic ticks. The block is a small FSM with registered count, status and reload storage.

## Interface
Parameters:
- none (width fixed at 4 bits)

Ports:
- `clk`  input  1  system clock, rising-edge active
- `reset_n`  input  1  asynchronous, active-low reset
- `load`  input  1  load `load_data` into count and reload register
- `load_data`  input  4  value to load
- `start`  input  1  begin or resume counting
- `stop`  input  1  pause counting, holding the current count
- `auto_reload`  input  1  on terminal count, reload and keep running (only with macro, see Configuration)
- `count`  output  4  current counter value, registered
- `busy`  output  1  high while in RUN, registered
- `done`  output  1  one-cycle terminal-count pulse, registered

One clock; reset is asynchronous and active-low.

## Operation
- Reset (`reset_n`=0, asynchronous):
  - `count`=0, `reload_reg`=0, state=IDLE
  - `busy`=0, `done`=0
- States:
  - IDLE: count holds.
  - RUN: count decrements by 1 per cycle.
- Input priority per edge: `load` > `stop` > `start`.
- `load` is accepted in any state:
  - `count` and `reload_reg` <= `load_data`
  - state -> IDLE
  - `done`=0 that cycle (suppresses a coincident terminal count)
- `stop`:
  - In RUN: state -> IDLE, count held.
  - In IDLE: no effect.
- `start`:
  - In IDLE with `count`!=0: state -> RUN.
  - In IDLE with `count`==0: `done` pulses on the next edge; state stays IDLE.
  - In RUN: ignored.
- Terminal count, in RUN when `count`==1:
  - Without reload: next `count`=0, `done`=1, state -> IDLE.
  - With reload active: next `count`=`reload_reg`, `done`=1, state stays RUN.
- `count` never wraps below 0. In RUN `count` is always >=1.
- `done` is high for exactly one cycle per terminal count, never for two consecutive cycles except in auto-reload with `reload_reg`==1.

## Timing
- `start` sampled at edge 0 with `count`=N:
  - After edge 0: `busy`=1, `count`=N.
  - Edges 1..N: one decrement each.
  - After edge N: `count`=0, `done`=1, `busy`=0.
  - Latency from `start` acceptance to `done` is N cycles.
- Auto-reload: `done` pulses every `reload_reg` cycles, coincident with `count` showing `reload_reg`.
- `load`, `stop` and `start` take effect on the first rising edge where they are sampled high; all outputs change only after that edge.
- Reset asserted mid-count: outputs go to reset values immediately, with no `done` pulse. After release the block waits in IDLE for `load`/`start`.
- `stop` and `start` asserted together in RUN: `stop` wins.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`.
- Defined: the `auto_reload` input is honoured at terminal count as described in Operation.
- Undefined:
  - `auto_reload` is ignored; the port remains present so instantiations do not change.
  - The block always stops at 0 and returns to IDLE.
  - `reload_reg` may be optimised away.

## Test plan
- Reset, then `load`=4'd5 and `start`: `busy`=1, `count` runs 5,4,3,2,1,0; `done`=1 in the cycle `count`=0; `busy`=0 in that same cycle.
- `load`=4'd0 then `start`: `done` pulses once on the next edge; `busy` stays 0; `count` stays 0.
- `load`=4'd9, `start`, then `stop` when `count`=6: `count` holds at 6 for 3 cycles; a second `start` resumes 5..0 with a single `done`.
- Auto-reload with the macro defined: `load`=4'd3, `auto_reload`=1, `start`: `done` every 3 cycles and `count` cycles 3,2,1,3,2,1. With the macro undefined: a single `done` and `count` stops at 0.
- `load`=4'd2 asserted in the same cycle `count`=1 during RUN: no `done`; `count`=2; state IDLE.
- `reset_n` pulsed low while `count`=7 in RUN: asynchronously `count`=0, `busy`=0, `done`=0; no `done` follows after release.

Source files
------------

// File: rtl/countdown_timer_4bit_if.sv
// Control/status bundle for countdown_timer_4bit: the sequencer side drives commands,
// the timer side returns count, busy and done.
interface countdown_timer_4bit_if;
    logic       load;
    logic [3:0] load_data;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       done;

    modport master (
        output load, load_data, start, stop, auto_reload,
        input  count, busy, done
    );

    modport slave (
        input  load, load_data, start, stop, auto_reload,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_timer_4bit.sv
// Loadable 4-bit down-counting timer with a one-cycle done pulse at terminal count.
// Define COUNTDOWN_AUTORELOAD_EN to honour auto_reload (reload and keep running at terminal count).
module countdown_timer_4bit (
    input  logic                  clk,
    input  logic                  reset_n,
    countdown_timer_4bit_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [3:0] count_q, count_nxt;
    logic [3:0] reload_q, reload_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       reload_hit;

`ifdef COUNTDOWN_AUTORELOAD_EN
    // A zero reload value would put RUN at count 0, so it falls back to stopping.
    assign reload_hit = bus.auto_reload && (reload_q != 4'd0);
`else
    logic unused_reload;
    assign reload_hit    = 1'b0;
    assign unused_reload = bus.auto_reload ^ (|reload_q);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count_q  <= 4'd0;
            reload_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        done_nxt   = 1'b0;

        if (bus.load) begin
            // Load wins over everything, including a coincident terminal count.
            count_nxt  = bus.load_data;
            reload_nxt = bus.load_data;
            state_nxt  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (count_q != 4'd0) begin
                            state_nxt = RUN;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else if (count_q == 4'd1) begin
                        done_nxt = 1'b1;
                        if (reload_hit) begin
                            count_nxt = reload_q;
                        end else begin
                            count_nxt = 4'd0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        count_nxt = count_q - 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt == RUN);
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_timer_4bit.sv
// Self-checking bench for countdown_timer_4bit: directed scenarios plus randomized
// command streams compared against a behavioural timer model.
module tb_countdown_timer_4bit;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    // Behavioural model: remaining ticks, reload value, running flag, pulse flag.
    logic [3:0] m_count;
    logic [3:0] m_reload;
    bit         m_run;
    bit         m_done;

    countdown_timer_4bit_if bus ();

    countdown_timer_4bit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count  = 4'd0;
        m_reload = 4'd0;
        m_run    = 0;
        m_done   = 0;
    endtask

    // Advance the model by one edge, using the commands currently on the bus.
    task automatic model_step();
        bit reload_on;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_on = bus.auto_reload;
`else
        reload_on = 0;
`endif
        if (bus.load) begin
            m_count  = bus.load_data;
            m_reload = bus.load_data;
            m_run    = 0;
            m_done   = 0;
        end else if (bus.stop) begin
            m_run  = 0;
            m_done = 0;
        end else if (m_run) begin
            m_done = (m_count == 4'd1);
            if (m_done && reload_on && m_reload != 0) begin
                m_count = m_reload;
            end else begin
                m_count = m_count - 4'd1;
                m_run   = (m_count != 0);
            end
        end else if (bus.start) begin
            m_done = (m_count == 0);
            m_run  = (m_count != 0);
        end else begin
            m_done = 0;
        end
    endtask

    task automatic tick(input logic ld, input logic [3:0] d, input logic st, input logic sp);
        bus.load      = ld;
        bus.load_data = d;
        bus.start     = st;
        bus.stop      = sp;
        model_step();
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.load        = 1'b0;
        bus.load_data   = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.auto_reload = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        reset_n = 1'b1;
        tick(0, 0, 0, 0);
        checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_idle got c=%0d b=%b d=%b want 0/0/0", bus.count, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic_count();
        tick(1, 4'd5, 0, 0);
        checks++; if (bus.count !== 4'd5 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_load got c=%0d b=%b want 5/0", bus.count, bus.busy);
        end
        tick(0, 0, 1, 0);
        checks++; if (bus.count !== 4'd5 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL basic_start got c=%0d b=%b d=%b want 5/1/0", bus.count, bus.busy, bus.done);
        end
        for (int i = 4; i >= 0; i--) begin
            tick(0, 0, 0, 0);
            checks++; if (bus.count !== 4'(i) || bus.busy !== (i != 0) || bus.done !== (i == 0)) begin
                errors++; $display("FAIL basic_step%0d got c=%0d b=%b d=%b want %0d/%b/%b",
                                   i, bus.count, bus.busy, bus.done, i, (i != 0), (i == 0));
            end
        end
        tick(0, 0, 0, 0);
        checks++; if (bus.done !== 1'b0 || bus.count !== 4'd0) begin
            errors++; $display("FAIL basic_after got c=%0d d=%b want 0/0", bus.count, bus.done);
        end
    endtask

    task automatic test_zero_start();
        tick(1, 4'd0, 0, 0);
        tick(0, 0, 1, 0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++; $display("FAIL zero_start got c=%0d b=%b d=%b want 0/0/1", bus.count, bus.busy, bus.done);
        end
        tick(0, 0, 0, 0);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++; $display("FAIL zero_after got c=%0d b=%b d=%b want 0/0/0", bus.count, bus.busy, bus.done);
        end
    endtask

    task automatic test_stop_resume();
        int dones;
        tick(1, 4'd9, 0, 0);
        tick(0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0);
        checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL stop_pre got %0d want 6", bus.count); end
        tick(0, 0, 1, 1);
        checks++; if (bus.count !== 4'd6 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stop_take got c=%0d b=%b want 6/0", bus.count, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (bus.count !== 4'd6 || bus.done !== 1'b0) begin
                errors++; $display("FAIL stop_hold%0d got c=%0d d=%b want 6/0", i, bus.count, bus.done);
            end
        end
        tick(0, 0, 1, 0);
        checks++; if (bus.count !== 4'd6 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL resume got c=%0d b=%b want 6/1", bus.count, bus.busy);
        end
        dones = 0;
        for (int i = 5; i >= 0; i--) begin
            tick(0, 0, 0, 0);
            if (bus.done === 1'b1) dones++;
            checks++; if (bus.count !== 4'(i)) begin
                errors++; $display("FAIL resume_step got %0d want %0d", bus.count, i);
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL resume_dones got %0d want 1", dones); end
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_c;
        logic       exp_d;
        logic       exp_b;
        bus.auto_reload = 1'b1;
        tick(1, 4'd3, 0, 0);
        tick(0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            tick(0, 0, 0, 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
            exp_c = (k % 3 == 0) ? 4'd3 : 4'(3 - (k % 3));
            exp_d = (k % 3 == 0);
            exp_b = 1'b1;
`else
            exp_c = (k < 3) ? 4'(3 - k) : 4'd0;
            exp_d = (k == 3);
            exp_b = (k < 3);
`endif
            checks++; if (bus.count !== exp_c || bus.done !== exp_d || bus.busy !== exp_b) begin
                errors++; $display("FAIL autoreload_k%0d got c=%0d d=%b b=%b want %0d/%b/%b",
                                   k, bus.count, bus.done, bus.busy, exp_c, exp_d, exp_b);
            end
        end
        bus.auto_reload = 1'b0;
        tick(0, 0, 0, 1);
    endtask

    task automatic test_load_override();
        tick(1, 4'd3, 0, 0);
        tick(0, 0, 1, 0);
        repeat (2) tick(0, 0, 0, 0);
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL override_pre got %0d want 1", bus.count); end
        tick(1, 4'd2, 0, 0);
        checks++; if (bus.count !== 4'd2 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL override got c=%0d d=%b b=%b want 2/0/0", bus.count, bus.done, bus.busy);
        end
        tick(0, 0, 0, 0);
        checks++; if (bus.count !== 4'd2 || bus.done !== 1'b0) begin
            errors++; $display("FAIL override_idle got c=%0d d=%b want 2/0", bus.count, bus.done);
        end
    endtask

    task automatic test_async_reset();
        tick(1, 4'd9, 0, 0);
        tick(0, 0, 1, 0);
        repeat (2) tick(0, 0, 0, 0);
        checks++; if (bus.count !== 4'd7 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre got c=%0d b=%b want 7/1", bus.count, bus.busy);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL areset_now got c=%0d b=%b d=%b want 0/0/0", bus.count, bus.busy, bus.done);
        end
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++; $display("FAIL areset_after%0d got c=%0d b=%b d=%b want 0/0/0",
                                   i, bus.count, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_random();
        logic       ld, st, sp;
        logic [3:0] d;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 11) == 0);
            d  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.auto_reload = ~bus.auto_reload;
            tick(ld, d, st, sp);
            checks++; if (bus.count !== m_count || bus.busy !== m_run || bus.done !== m_done) begin
                errors++; $display("FAIL random_%0d got c=%0d b=%b d=%b want %0d/%b/%b",
                                   i, bus.count, bus.busy, bus.done, m_count, m_run, m_done);
            end
        end
        bus.auto_reload = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_count();
        test_zero_start();
        test_stop_resume();
        test_auto_reload();
        test_load_override();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
